// File: rtl/pe_types_pkg.sv
// Shared PE types: accumulator configuration, drain debug status, saturation pattern helper.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package pe_types;

  typedef struct packed {
    int RESULT_WIDTH;
    int RESULT_EXPONENT_WIDTH;
    int RESULT_MANTISSA_WIDTH;
    int ACCUM_LATENCY;
  } pe_cfg_t;

  localparam pe_cfg_t PE_CFG_DEFAULT = '{
    RESULT_WIDTH:          16,
    RESULT_EXPONENT_WIDTH: 5,
    RESULT_MANTISSA_WIDTH: 10,
    ACCUM_LATENCY:         6
  };

  // Widest result the saturation helper can describe.
  localparam int PE_MAX_RESULT_WIDTH = 64;
  localparam int PE_DRAIN_SAT_COUNT_WIDTH = 16;

  typedef struct packed {
    logic                                overflow;
    logic [PE_DRAIN_SAT_COUNT_WIDTH-1:0] sat_count;
  } pe_drain_status_t;

  // Largest finite magnitude {sign, all-ones-1, all-ones}: the value the accumulator clamps to.
  function automatic logic [PE_MAX_RESULT_WIDTH-1:0] result_sat_pattern(pe_cfg_t c, logic sign);
    logic [PE_MAX_RESULT_WIDTH-1:0] exp_f;
    logic [PE_MAX_RESULT_WIDTH-1:0] man_f;
    logic [PE_MAX_RESULT_WIDTH-1:0] sgn_f;
    man_f = (64'd1 << c.RESULT_MANTISSA_WIDTH) - 64'd1;
    exp_f = ((64'd1 << c.RESULT_EXPONENT_WIDTH) - 64'd2) << c.RESULT_MANTISSA_WIDTH;
    sgn_f = {63'd0, sign} << (c.RESULT_EXPONENT_WIDTH + c.RESULT_MANTISSA_WIDTH);
    return sgn_f | exp_f | man_f;
  endfunction

endpackage

// File: rtl/pe_result_fifo.sv
// Small FIFO with a registered head: storage, wrapping pointers, level, full/empty.
// Latency: push visible at dat/vld one cycle later (no fall-through).
// Backpressure: pop on vld && pop_rdy; a push into a full FIFO without a pop is dropped and flagged.
module pe_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_rdy,
  output logic                     vld,
  output logic [WIDTH-1:0]         dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_nxt;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             pop, push, full;

  // Next-state: a full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    pop      = valid_q && pop_rdy;
    full     = (count_q == CNT_FULL);
    push     = push_vld && (!full || pop);
    drop     = push_vld && full && !pop;
    rd_nxt   = rd_ptr_q + AW'(1);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_nxt : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    valid_d  = (count_d != '0);
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
    end
    // Head register tracks whatever entry will sit at the read pointer next cycle.
    head_d = head_q;
    if (push && ((count_q == '0) || (pop && (count_q == CNT_ONE)))) begin
      head_d = push_dat;
    end else if (pop && (count_q > CNT_ONE)) begin
      head_d = mem_q[rd_nxt];
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign vld   = valid_q;
  assign dat   = head_q;
  assign level = count_q;

endmodule

// File: rtl/pe_result_drain.sv
// Recovers the accumulator result strobe from its flush pulse and queues each result on a valid/ready stream.
// Latency: flush at t -> capture at end of t+ACCUM_LATENCY -> o_valid at t+ACCUM_LATENCY+1 (empty FIFO).
// Backpressure: results queue while i_ready is low; captures into a full FIFO are dropped (sticky o_overflow). Option macro: PE_DRAIN_RELU_EN.
module pe_result_drain
  import pe_types::*;
#(
  parameter pe_cfg_t cfg             = PE_CFG_DEFAULT,
  parameter int      FIFO_DEPTH      = 8,
  parameter int      SAT_COUNT_WIDTH = 16
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic                            i_flush_accumulator,
  input  logic [cfg.RESULT_WIDTH-1:0]     i_result,
  input  logic                            i_ready,
  input  logic                            i_clear_overflow,
  output logic                            o_valid,
  output logic [cfg.RESULT_WIDTH-1:0]     o_data,
  output logic [$clog2(FIFO_DEPTH):0]     o_level,
  output logic                            o_overflow,
  output logic [SAT_COUNT_WIDTH-1:0]      o_sat_count
);

  localparam int RW  = cfg.RESULT_WIDTH;
  localparam int LAT = cfg.ACCUM_LATENCY;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "pe_result_drain: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (LAT < 1) begin : g_bad_latency
    $fatal(1, "pe_result_drain: ACCUM_LATENCY must be >= 1");
  end
  if (RW != 1 + cfg.RESULT_EXPONENT_WIDTH + cfg.RESULT_MANTISSA_WIDTH) begin : g_bad_width
    $fatal(1, "pe_result_drain: RESULT_WIDTH must equal 1 + exponent + mantissa");
  end

  logic [LAT-1:0]             dly_q, dly_d;
  logic                       ovf_q, ovf_d;
  logic [SAT_COUNT_WIDTH-1:0] sat_q, sat_d;
  logic                       strobe;
  logic                       sat_hit;
  logic [RW-1:0]              push_dat;
  logic                       fifo_drop;

  // Flush delay line; its last stage lines up with the accumulator's result cycle.
  always_comb begin
    dly_d    = dly_q << 1;
    dly_d[0] = i_flush_accumulator;
  end

  assign strobe  = dly_q[LAT-1];
  assign sat_hit = (i_result == RW'(result_sat_pattern(cfg, i_result[RW-1])));

  // Value written to the FIFO; ReLU forces negative results (including -0) to +0.
  always_comb begin
    push_dat = i_result;
`ifdef PE_DRAIN_RELU_EN
    if (i_result[RW-1]) begin
      push_dat = '0;
    end
`endif
  end

  // Debug state: sticky overflow (drop beats clear) and a saturating count of clamped results.
  always_comb begin
    ovf_d = ovf_q;
    if (fifo_drop) begin
      ovf_d = 1'b1;
    end else if (i_clear_overflow) begin
      ovf_d = 1'b0;
    end
    sat_d = sat_q;
    if (strobe && sat_hit && (sat_q != '1)) begin
      sat_d = sat_q + SAT_COUNT_WIDTH'(1);
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dly_q <= '0;
      ovf_q <= 1'b0;
      sat_q <= '0;
    end else begin
      dly_q <= dly_d;
      ovf_q <= ovf_d;
      sat_q <= sat_d;
    end
  end

  pe_result_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clock),
    .rst_n    (resetn),
    .push_vld (strobe),
    .push_dat (push_dat),
    .pop_rdy  (i_ready),
    .vld      (o_valid),
    .dat      (o_data),
    .level    (o_level),
    .drop     (fifo_drop)
  );

  assign o_overflow  = ovf_q;
  assign o_sat_count = sat_q;

endmodule
